// File: rtl/soc_riscv_apb_arbiter_if.sv
// Requester and APB bus bundle for soc_riscv_apb_arbiter.
// The arbiter connects through the master modport; the requesters and the APB slave use the slave modport.
interface soc_riscv_apb_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8
);
  logic [NREQ-1:0]              REQ;
  logic [NREQ*PADDR_SIZE-1:0]   REQ_ADDR;
  logic [NREQ-1:0]              REQ_WRITE;
  logic [NREQ*PDATA_SIZE-1:0]   REQ_WDATA;
  logic [NREQ*PDATA_SIZE/8-1:0] REQ_STRB;
  logic [NREQ*3-1:0]            REQ_PROT;
  logic [NREQ-1:0]              DONE;
  logic [PDATA_SIZE-1:0]        RDATA;
  logic                         ERR;
  logic [NREQ-1:0]              GNT;
  logic                         PSEL;
  logic                         PENABLE;
  logic [PADDR_SIZE-1:0]        PADDR;
  logic                         PWRITE;
  logic [PDATA_SIZE-1:0]        PWDATA;
  logic [PDATA_SIZE/8-1:0]      PSTRB;
  logic [2:0]                   PPROT;
  logic [PDATA_SIZE-1:0]        PRDATA;
  logic                         PREADY;
  logic                         PSLVERR;

  modport master (
    input  REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB, REQ_PROT, PRDATA, PREADY, PSLVERR,
    output DONE, RDATA, ERR, GNT, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB, REQ_PROT, PRDATA, PREADY, PSLVERR,
    input  DONE, RDATA, ERR, GNT, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/soc_riscv_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Optional ACCESS-phase timeout enabled by defining SOC_RISCV_APB_ARBITER_TIMEOUT_EN.
module soc_riscv_apb_arbiter #(
  parameter int NREQ       = 2,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 255
) (
  input logic                    HCLK,
  input logic                    HRESET,
  soc_riscv_apb_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int SW = PDATA_SIZE / 8;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535 || (PDATA_SIZE % 8) != 0) begin : g_param_check
    $error("soc_riscv_apb_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                state_r, state_s;
  logic [IW-1:0]         last_r, last_s, owner_r, owner_s, win_s;
  logic [NREQ-1:0]       gnt_r, gnt_s, done_r, done_s;
  logic [PDATA_SIZE-1:0] rdata_r, rdata_s, pwdata_r, pwdata_s;
  logic                  err_r, err_s, psel_r, psel_s, penable_r, penable_s, pwrite_r, pwrite_s;
  logic [PADDR_SIZE-1:0] paddr_r, paddr_s;
  logic [SW-1:0]         pstrb_r, pstrb_s;
  logic [2:0]            pprot_r, pprot_s;
  logic [IW:0]           pick_s;
  logic                  grant_s, tout_s;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
  logic [15:0]           cnt_r, cnt_s;
`endif

  // {found, index} of the first set bit after 'last', wrapping around.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) res = {1'b1, IW'(idx)};
      else        res = res;
    end
    return res;
  endfunction

  // Next-state and next-output computation for the SETUP/ACCESS sequencer.
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    owner_s   = owner_r;
    gnt_s     = gnt_r;
    psel_s    = psel_r;
    penable_s = penable_r;
    paddr_s   = paddr_r;
    pwrite_s  = pwrite_r;
    pwdata_s  = pwdata_r;
    pstrb_s   = pstrb_r;
    pprot_s   = pprot_r;
    done_s    = '0;
    rdata_s   = '0;
    err_s     = 1'b0;
    grant_s   = 1'b0;
    tout_s    = 1'b0;
    pick_s    = rr_pick(bus.REQ, last_r);
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
    cnt_s     = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s[IW]) grant_s = 1'b1;
        else            state_s = IDLE;
      end
      SETUP: begin
        penable_s = 1'b1;
        state_s   = ACCESS;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
        cnt_s     = 16'd0;
`endif
      end
      ACCESS: begin
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
        // A wait cycle that would bring the count to TIMEOUT ends the transfer.
        if (!bus.PREADY && cnt_r == 16'(TIMEOUT - 1)) tout_s = 1'b1;
        else                                           tout_s = 1'b0;
        if (!bus.PREADY && !tout_s) cnt_s = cnt_r + 16'd1;
        else                        cnt_s = cnt_r;
`endif
        if (bus.PREADY || tout_s) begin
          done_s[owner_r] = 1'b1;
          rdata_s = (pwrite_r || tout_s) ? '0 : bus.PRDATA;
          err_s   = bus.PSLVERR | tout_s;
          last_s  = owner_r;
          // The owner still holds REQ this cycle, so it is excluded from the re-arbitration.
          pick_s  = rr_pick(bus.REQ & ~(NREQ'(1) << owner_r), owner_r);
          if (pick_s[IW]) begin
            grant_s = 1'b1;
          end else begin
            state_s   = IDLE;
            psel_s    = 1'b0;
            penable_s = 1'b0;
            gnt_s     = '0;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      default: begin
        state_s   = IDLE;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        gnt_s     = '0;
      end
    endcase
    win_s = pick_s[IW-1:0];
    if (grant_s) begin
      owner_s   = win_s;
      gnt_s     = NREQ'(1) << win_s;
      psel_s    = 1'b1;
      penable_s = 1'b0;
      paddr_s   = bus.REQ_ADDR[int'(win_s)*PADDR_SIZE +: PADDR_SIZE];
      pwrite_s  = bus.REQ_WRITE[win_s];
      pwdata_s  = bus.REQ_WDATA[int'(win_s)*PDATA_SIZE +: PDATA_SIZE];
      pstrb_s   = bus.REQ_WRITE[win_s] ? bus.REQ_STRB[int'(win_s)*SW +: SW] : '0;
      pprot_s   = bus.REQ_PROT[int'(win_s)*3 +: 3];
      state_s   = SETUP;
    end else begin
      owner_s   = owner_r;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r   <= IDLE;
      last_r    <= IW'(NREQ - 1);
      owner_r   <= '0;
      gnt_r     <= '0;
      done_r    <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      paddr_r   <= '0;
      pwrite_r  <= 1'b0;
      pwdata_r  <= '0;
      pstrb_r   <= '0;
      pprot_r   <= 3'd0;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
      cnt_r     <= 16'd0;
`endif
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      owner_r   <= owner_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      psel_r    <= psel_s;
      penable_r <= penable_s;
      paddr_r   <= paddr_s;
      pwrite_r  <= pwrite_s;
      pwdata_r  <= pwdata_s;
      pstrb_r   <= pstrb_s;
      pprot_r   <= pprot_s;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
      cnt_r     <= cnt_s;
`endif
    end
  end

  assign bus.DONE    = done_r;
  assign bus.RDATA   = rdata_r;
  assign bus.ERR     = err_r;
  assign bus.GNT     = gnt_r;
  assign bus.PSEL    = psel_r;
  assign bus.PENABLE = penable_r;
  assign bus.PADDR   = paddr_r;
  assign bus.PWRITE  = pwrite_r;
  assign bus.PWDATA  = pwdata_r;
  assign bus.PSTRB   = pstrb_r;
  assign bus.PPROT   = pprot_r;
endmodule

// File: tb/tb_soc_riscv_apb_arbiter.sv
// Bench for soc_riscv_apb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_soc_riscv_apb_arbiter;
  localparam int NREQ = 2;
  localparam int PA   = 10;
  localparam int PD   = 8;
  localparam int PS   = PD / 8;
  localparam int TO   = 4;
  localparam int AW   = NREQ * PA;
  localparam int DW   = NREQ * PD;
  localparam int SWT  = NREQ * PS;
  localparam int PW   = NREQ * 3;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  soc_riscv_apb_arbiter_if #(.NREQ(NREQ), .PADDR_SIZE(PA), .PDATA_SIZE(PD)) bus ();
  soc_riscv_apb_arbiter #(.NREQ(NREQ), .PADDR_SIZE(PA), .PDATA_SIZE(PD), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transfer record plus the rotating pointer.
  logic            model_on = 1'b0;
  logic            m_busy, m_access;
  int              m_owner, m_last, m_waits;
  logic [NREQ-1:0] e_gnt, e_done;
  logic [PD-1:0]   e_rdata, e_pwdata;
  logic            e_err, e_psel, e_pen, e_pwrite;
  logic [PA-1:0]   e_paddr;
  logic [PS-1:0]   e_pstrb;
  logic [2:0]      e_pprot;

  function automatic int rr(input logic [NREQ-1:0] r, input int last, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_grant(input int p);
    m_busy   = 1'b1;
    m_access = 1'b0;
    m_owner  = p;
    e_psel   = 1'b1;
    e_pen    = 1'b0;
    e_gnt    = '0;
    e_gnt[p] = 1'b1;
    e_paddr  = bus.REQ_ADDR[p*PA +: PA];
    e_pwrite = bus.REQ_WRITE[p];
    e_pwdata = bus.REQ_WDATA[p*PD +: PD];
    e_pstrb  = bus.REQ_WRITE[p] ? bus.REQ_STRB[p*PS +: PS] : '0;
    e_pprot  = bus.REQ_PROT[p*3 +: 3];
  endtask

  task automatic model_step();
    int   p;
    logic fin, tout;
    e_done  = '0;
    e_rdata = '0;
    e_err   = 1'b0;
    if (HRESET) begin
      model_on = 1'b1;
      m_busy = 1'b0; m_access = 1'b0; m_last = NREQ - 1; m_owner = 0; m_waits = 0;
      e_gnt = '0; e_psel = 1'b0; e_pen = 1'b0; e_paddr = '0; e_pwrite = 1'b0;
      e_pwdata = '0; e_pstrb = '0; e_pprot = 3'd0;
    end else if (!m_busy) begin
      p = rr(bus.REQ, m_last, -1);
      if (p >= 0) m_grant(p);
    end else if (!m_access) begin
      e_pen = 1'b1; m_access = 1'b1; m_waits = 0;
    end else begin
      fin  = bus.PREADY;
      tout = 1'b0;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
      if (!fin) begin
        m_waits++;
        if (m_waits == TO) begin fin = 1'b1; tout = 1'b1; end
      end
`endif
      if (fin) begin
        e_done[m_owner] = 1'b1;
        e_err   = tout ? 1'b1 : bus.PSLVERR;
        e_rdata = (tout || e_pwrite) ? '0 : bus.PRDATA;
        m_last  = m_owner;
        p = rr(bus.REQ, m_last, m_owner);
        if (p >= 0) m_grant(p);
        else begin m_busy = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_gnt = '0; end
      end
    end
  endtask

  always @(posedge HCLK) model_step();

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge HCLK) begin
    if (model_on) begin
      chk("GNT", bus.GNT, e_gnt);
      chk("DONE", bus.DONE, e_done);
      chk("RDATA", bus.RDATA, e_rdata);
      chk("ERR", bus.ERR, e_err);
      chk("PSEL", bus.PSEL, e_psel);
      chk("PENABLE", bus.PENABLE, e_pen);
      chk("PADDR", bus.PADDR, e_paddr);
      chk("PWRITE", bus.PWRITE, e_pwrite);
      chk("PWDATA", bus.PWDATA, e_pwdata);
      chk("PSTRB", bus.PSTRB, e_pstrb);
      chk("PPROT", bus.PPROT, e_pprot);
    end
  end

  task automatic set_req(input int i, input logic [PA-1:0] a, input logic w, input logic [PD-1:0] d,
                         input logic [PS-1:0] s, input logic [2:0] p);
    bus.REQ[i]              = 1'b1;
    bus.REQ_ADDR[i*PA +: PA] = a;
    bus.REQ_WRITE[i]        = w;
    bus.REQ_WDATA[i*PD +: PD] = d;
    bus.REQ_STRB[i*PS +: PS] = s;
    bus.REQ_PROT[i*3 +: 3]  = p;
  endtask

  int              ns, drops, acc;
  logic [NREQ-1:0] seq [4];

  initial begin
    HRESET = 1'b1;
    bus.REQ = '0; bus.REQ_ADDR = '0; bus.REQ_WRITE = '0; bus.REQ_WDATA = '0;
    bus.REQ_STRB = '0; bus.REQ_PROT = '0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_psel", bus.PSEL, 32'd0);
    chk("rst_gnt", bus.GNT, 32'd0);
    HRESET = 1'b0;

    // Single write from requester 0.
    set_req(0, 10'h12A, 1'b1, 8'h5C, 1'b1, 3'b010);
    @(negedge HCLK);
    chk("t1_psel", bus.PSEL, 32'd1);
    chk("t1_pen0", bus.PENABLE, 32'd0);
    chk("t1_paddr", bus.PADDR, 32'h12A);
    chk("t1_pstrb", bus.PSTRB, 32'd1);
    chk("t1_gnt", bus.GNT, 32'd1);
    @(negedge HCLK);
    chk("t1_pen1", bus.PENABLE, 32'd1);
    bus.PREADY = 1'b1;
    @(negedge HCLK);
    chk("t1_done", bus.DONE, 32'd1);
    chk("t1_err", bus.ERR, 32'd0);
    chk("t1_idle", bus.PSEL, 32'd0);
    chk("t1_hold_addr", bus.PADDR, 32'h12A);
    bus.PREADY = 1'b0; bus.REQ = '0;

    // Read from requester 1 with three wait states.
    set_req(1, 10'h004, 1'b0, 8'hFF, 1'b1, 3'b001);
    @(negedge HCLK);
    chk("t2_gnt", bus.GNT, 32'd2);
    chk("t2_pstrb", bus.PSTRB, 32'd0);
    for (int w = 0; w < 4; w++) begin
      @(negedge HCLK);
      chk("t2_stable", {bus.PENABLE, bus.PADDR}, {1'b1, 10'h004});
      if (w == 3) begin bus.PREADY = 1'b1; bus.PRDATA = 8'hA7; end
    end
    @(negedge HCLK);
    chk("t2_done", bus.DONE, 32'd2);
    chk("t2_rdata", bus.RDATA, 32'hA7);
    bus.PREADY = 1'b0; bus.REQ = '0; bus.PRDATA = '0;

    // Contention: both requesters held, expect strict alternation without idle cycles.
    set_req(0, 10'h010, 1'b1, 8'h11, 1'b1, 3'b000);
    set_req(1, 10'h020, 1'b1, 8'h22, 1'b1, 3'b000);
    bus.PREADY = 1'b1;
    ns = 0; drops = 0;
    for (int c = 0; c < 20 && ns < 4; c++) begin
      @(negedge HCLK);
      if (ns > 0 && !bus.PSEL) drops++;
      if (bus.PSEL && !bus.PENABLE) begin seq[ns] = bus.GNT; ns++; end
    end
    bus.REQ = '0;
    chk("t3_count", ns, 32'd4);
    chk("t3_seq0", seq[0], 32'd1);
    chk("t3_seq1", seq[1], 32'd2);
    chk("t3_seq2", seq[2], 32'd1);
    chk("t3_seq3", seq[3], 32'd2);
    chk("t3_nodrop", drops, 32'd0);
    repeat (3) @(negedge HCLK);
    bus.PREADY = 1'b0;

    // Slave error on a write.
    set_req(0, 10'h0F0, 1'b1, 8'h33, 1'b1, 3'b000);
    repeat (2) @(negedge HCLK);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
    @(negedge HCLK);
    chk("t4_done", bus.DONE, 32'd1);
    chk("t4_err", bus.ERR, 32'd1);
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.REQ = '0;
    @(negedge HCLK);
    chk("t4_err_clr", bus.ERR, 32'd0);

    // Reset in the middle of ACCESS, then pointer back to requester 0 first.
    set_req(1, 10'h155, 1'b0, 8'h00, 1'b0, 3'b000);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("t5_rst", {bus.PSEL, bus.PENABLE, bus.GNT, bus.DONE}, 32'd0);
    HRESET = 1'b0;
    set_req(0, 10'h0AA, 1'b1, 8'h44, 1'b1, 3'b000);
    @(negedge HCLK);
    chk("t5_gnt0", bus.GNT, 32'd1);
    bus.REQ = '0; bus.PREADY = 1'b1;
    repeat (4) @(negedge HCLK);
    bus.PREADY = 1'b0;

    // Slave that never answers.
    bus.PRDATA = 8'h3C;
    set_req(0, 10'h0C0, 1'b0, 8'h00, 1'b0, 3'b000);
    @(negedge HCLK);
    acc = 0;
`ifdef SOC_RISCV_APB_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 50; c++) begin
      @(negedge HCLK);
      if (bus.DONE != '0) break;
      acc++;
    end
    chk("t6_waits", acc, TO);
    chk("t6_done", bus.DONE, 32'd1);
    chk("t6_err", bus.ERR, 32'd1);
    chk("t6_rdata", bus.RDATA, 32'd0);
    bus.REQ = '0; bus.PREADY = 1'b1;
    @(negedge HCLK);
    chk("t6_late", bus.DONE, 32'd0);
    bus.PREADY = 1'b0;
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge HCLK);
      if (bus.DONE != '0) acc++;
    end
    chk("t6_nodone", acc, 32'd0);
    bus.PREADY = 1'b1;
    @(negedge HCLK);
    chk("t6_done", bus.DONE, 32'd1);
    chk("t6_rdata", bus.RDATA, 32'h3C);
    bus.REQ = '0; bus.PREADY = 1'b0;
`endif
    repeat (3) @(negedge HCLK);

    // Random traffic, including requests dropped before or after grant and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge HCLK);
      HRESET        = ($urandom_range(0, 299) == 0);
      bus.REQ       = NREQ'($urandom);
      bus.REQ_ADDR  = AW'($urandom);
      bus.REQ_WRITE = NREQ'($urandom);
      bus.REQ_WDATA = DW'($urandom);
      bus.REQ_STRB  = SWT'($urandom);
      bus.REQ_PROT  = PW'($urandom);
      bus.PREADY    = ($urandom_range(0, 2) != 0);
      bus.PSLVERR   = ($urandom_range(0, 3) == 0);
      bus.PRDATA    = PD'($urandom);
    end
    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
